// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter: FSM encoding,
// parameter defaults matching the uart core, and the round-robin wrap helper.
package uart_tx_arbiter_pkg;

  localparam int DBIT_DEF    = 8;
  localparam int NREQ_DEF    = 4;
  localparam int MAX_LEN_DEF = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_e;

  // Index of the requester after idx, wrapping from nreq-1 back to 0.
  function automatic int rr_next(input int idx, input int nreq);
    return (idx == nreq - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning from rr_ptr
// upward, modulo NREQ.
module uart_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan from the far end so the candidate closest to rr_ptr is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NREQ]) begin
        any = 1'b1;
        idx = IDX_W'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART tx FIFO between NREQ message sources; a granted source owns
// the FIFO until its 'last' byte is written or MAX_LEN bytes force a release.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int NREQ    = NREQ_DEF,
  parameter int IDX_W   = 2,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DBIT-1:0] data,
  input  logic [NREQ-1:0]      last,
  output logic [NREQ-1:0]      ack,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [DBIT-1:0]      w_data,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 len_err,
  output arb_state_e           state_dbg,
  output logic [IDX_W-1:0]     rr_ptr_dbg,
  output logic [LEN_W-1:0]     cnt_dbg
);

  // Handshake: a byte of source i transfers in the cycle where the arbiter is
  // in SEND with grant_id==i, req[i]=1 and tx_full=0; that cycle wr_uart and
  // ack[i] are both high. The source holds data/last stable until ack[i].

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  uart_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    wr_uart = 1'b0;
    ack     = '0;
    w_data  = '0;
    busy    = 1'b0;
    len_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        busy          = 1'b1;
        w_data        = data[int'(grant_q)*DBIT +: DBIT];
        wr_uart       = req[grant_q] & ~tx_full;
        ack[grant_q]  = wr_uart;
        if (wr_uart) begin
          if (last[grant_q] || cnt_q == LEN_W'(MAX_LEN - 1)) begin
            // Forced release: the rest of the message re-arbitrates as new.
            len_err = ~last[grant_q];
            state_d = ST_IDLE;
            rr_d    = IDX_W'(rr_next(int'(grant_q), NREQ));
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_id   = grant_q;
  assign state_dbg  = state_q;
  assign rr_ptr_dbg = rr_q;
  assign cnt_dbg    = cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: inputs change on the falling edge and
// outputs are checked 1 ns later, against hand-computed expectations.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int DBIT = 8;
  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DBIT-1:0] data = '0;
  logic [NREQ-1:0]      last = '0;
  logic [NREQ-1:0]      ack;
  logic                 tx_full = 1'b0;
  logic                 wr_uart;
  logic [DBIT-1:0]      w_data;
  logic                 busy;
  logic [1:0]           grant_id;
  logic                 len_err;
  arb_state_e           state_dbg;
  logic [1:0]           rr_ptr_dbg;
  logic [3:0]           cnt_dbg;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data       (data),
    .last       (last),
    .ack        (ack),
    .tx_full    (tx_full),
    .wr_uart    (wr_uart),
    .w_data     (w_data),
    .busy       (busy),
    .grant_id   (grant_id),
    .len_err    (len_err),
    .state_dbg  (state_dbg),
    .rr_ptr_dbg (rr_ptr_dbg),
    .cnt_dbg    (cnt_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_wr, input logic [3:0] e_ack,
                         input logic [7:0] e_wd, input logic e_busy, input logic e_lerr);
    chk({tag, ".wr"},   32'(wr_uart), 32'(e_wr));
    chk({tag, ".ack"},  32'(ack),     32'(e_ack));
    if (e_busy) chk({tag, ".wdata"}, 32'(w_data), 32'(e_wd));
    chk({tag, ".busy"}, 32'(busy),    32'(e_busy));
    chk({tag, ".lerr"}, 32'(len_err), 32'(e_lerr));
  endtask

  task automatic set_src(input int i, input logic [7:0] b, input logic l);
    data[i*DBIT +: DBIT] = b;
    last[i] = l;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); #1;
    chk_out("rst", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("rst.wdata", 32'(w_data), 32'h0);
    chk("rst.state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst.rr", 32'(rr_ptr_dbg), 32'h0);
    chk("rst.gid", 32'(grant_id), 32'h0);
    tick(); reset = 1'b1;

    // T2: src0 and src2 request together, 3-byte messages each
    tick(); req = 4'b0101; set_src(0, 8'h01, 1'b0); set_src(2, 8'h21, 1'b0); #1;
    chk_out("t2.idle0", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    tick(); #1;
    chk_out("t2.s0b0", 1'b1, 4'b0001, 8'h01, 1'b1, 1'b0);
    chk("t2.gid0", 32'(grant_id), 32'd0);
    tick(); set_src(0, 8'h02, 1'b0); #1;
    chk_out("t2.s0b1", 1'b1, 4'b0001, 8'h02, 1'b1, 1'b0);
    tick(); set_src(0, 8'h03, 1'b1); #1;
    chk_out("t2.s0b2", 1'b1, 4'b0001, 8'h03, 1'b1, 1'b0);
    tick(); req = 4'b0100; set_src(0, 8'h00, 1'b0); #1;
    chk_out("t2.bubble", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("t2.rr1", 32'(rr_ptr_dbg), 32'd1);
    tick(); #1;
    chk_out("t2.s2b0", 1'b1, 4'b0100, 8'h21, 1'b1, 1'b0);
    chk("t2.gid2", 32'(grant_id), 32'd2);
    tick(); set_src(2, 8'h22, 1'b0); #1;
    chk_out("t2.s2b1", 1'b1, 4'b0100, 8'h22, 1'b1, 1'b0);
    tick(); set_src(2, 8'h23, 1'b1); #1;
    chk_out("t2.s2b2", 1'b1, 4'b0100, 8'h23, 1'b1, 1'b0);

    // T3: src3 single-byte message, then 1001 -> src0 wins after wrap
    tick(); req = 4'b1000; set_src(2, 8'h00, 1'b0); set_src(3, 8'h31, 1'b1); #1;
    chk_out("t3.idle", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("t3.rr3", 32'(rr_ptr_dbg), 32'd3);
    tick(); #1;
    chk_out("t3.s3", 1'b1, 4'b1000, 8'h31, 1'b1, 1'b0);
    tick(); req = 4'b1001; set_src(0, 8'h41, 1'b1); set_src(3, 8'h51, 1'b1); #1;
    chk("t3.rrwrap", 32'(rr_ptr_dbg), 32'd0);
    tick(); #1;
    chk_out("t3.win0", 1'b1, 4'b0001, 8'h41, 1'b1, 1'b0);
    chk("t3.gid0", 32'(grant_id), 32'd0);
    tick(); req = 4'b1000; #1;
    chk_out("t3.bubble", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    tick(); #1;
    chk_out("t3.then3", 1'b1, 4'b1000, 8'h51, 1'b1, 1'b0);

    // T4: tx_full stalls src1 for 5 cycles mid-message
    tick(); req = 4'b0010; set_src(3, 8'h00, 1'b0); set_src(1, 8'h10, 1'b0); #1;
    chk_out("t4.idle", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    tick(); #1;
    chk_out("t4.b0", 1'b1, 4'b0010, 8'h10, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick(); tx_full = 1'b1; set_src(1, 8'hA5, 1'b1); #1;
      chk_out($sformatf("t4.full%0d", c), 1'b0, 4'h0, 8'hA5, 1'b1, 1'b0);
      chk($sformatf("t4.cnt%0d", c), 32'(cnt_dbg), 32'd1);
    end
    tick(); tx_full = 1'b0; #1;
    chk_out("t4.resume", 1'b1, 4'b0010, 8'hA5, 1'b1, 1'b0);

    // T5: src1 sends 16 bytes with no last -> forced release on the 16th
    tick(); set_src(1, 8'h80, 1'b0); #1;
    chk_out("t5.idle", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      tick(); set_src(1, 8'(8'h80 + k), 1'b0); #1;
      chk_out($sformatf("t5.b%0d", k), 1'b1, 4'b0010, 8'(8'h80 + k), 1'b1, (k == 15));
    end
    tick(); set_src(1, 8'h90, 1'b1); #1;
    chk_out("t5.released", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("t5.rr2", 32'(rr_ptr_dbg), 32'd2);
    tick(); #1;
    chk_out("t5.recompete", 1'b1, 4'b0010, 8'h90, 1'b1, 1'b0);

    // T1: reset asserted mid-SEND
    tick(); req = 4'b0001; set_src(1, 8'h00, 1'b0); set_src(0, 8'h77, 1'b0); #1;
    chk_out("t1.idle", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    tick(); #1;
    chk_out("t1.b0", 1'b1, 4'b0001, 8'h77, 1'b1, 1'b0);
    tick(); set_src(0, 8'h78, 1'b0); #1;
    chk_out("t1.b1", 1'b1, 4'b0001, 8'h78, 1'b1, 1'b0);
    reset = 1'b0; #1;
    chk_out("t1.async", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("t1.wdata", 32'(w_data), 32'h0);
    chk("t1.state", 32'(state_dbg), 32'(ST_IDLE));
    chk("t1.rr", 32'(rr_ptr_dbg), 32'd0);
    chk("t1.cnt", 32'(cnt_dbg), 32'd0);
    tick(); #1;
    chk_out("t1.held", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    tick(); req = 4'b0000; reset = 1'b1; #1;
    chk_out("t1.after", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    tick(); #1;
    chk("t1.stayidle", 32'(state_dbg), 32'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
